maxpool2x2_stream: RTL and testbench

Streaming 2×2 / stride-2 max-pooling stage sitting directly downstream of the convolution unit. It consumes the float16 ReLU'd output pixels in raster order and buffers one half-width row of horizontal maxima. It emits one pooled float16 pixel per 2×2 window over a valid/ready handshake, and signals frame completion to the layer controller.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/maxpool2x2_stream_if.sv | 21 ++
 rtl/fp16_max.sv | 34 +++
 rtl/maxpool2x2_stream.sv | 154 +++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 / stride-2 float16 max-pooling stage.
package pool_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        ROW_EVEN,
        ROW_ODD,
        DRAIN
    } pool_state_e;

    localparam fp16_t FP16_POS_ZERO = 16'h0000;

    // Any value with the sign bit set, including -0, becomes +0.
    function automatic fp16_t fp16_relu_clamp(fp16_t x);
        return x[15] ? FP16_POS_ZERO : x;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Input and output pixel streams of the pooling stage; the stage is the slave end.
interface maxpool2x2_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_max.sv
// Combinational float16 max; returns a when a >= b, so +0/-0 ties keep a.
module fp16_max
    import pool_pkg::*;
(
    input  fp16_t a_i,
    input  fp16_t b_i,
    output fp16_t y_o
);

    logic        a_neg, b_neg;
    logic [14:0] a_mag, b_mag;
    logic        a_ge_b;

    assign a_neg = a_i[15];
    assign b_neg = b_i[15];
    assign a_mag = a_i[14:0];
    assign b_mag = b_i[14:0];

    always_comb begin
        a_ge_b = 1'b1;
        if (a_mag == '0 && b_mag == '0) begin
            a_ge_b = 1'b1;
        end else if (a_neg != b_neg) begin
            a_ge_b = !a_neg;
        end else if (!a_neg) begin
            a_ge_b = (a_mag >= b_mag);
        end else begin
            a_ge_b = (a_mag <= b_mag);
        end
    end

    assign y_o = a_ge_b ? a_i : b_i;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 float16 max-pool with a half-width row buffer.
// Optional MAXPOOL_RELU_CLAMP_EN: negative inputs (incl. -0) are forced to +0.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 256,
    parameter int MAX_HEIGHT = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
    maxpool2x2_stream_if.slave              strm,
    output logic                            busy,
    output logic                            done
);

    localparam int CW    = $clog2(MAX_WIDTH + 1);
    localparam int HW    = $clog2(MAX_HEIGHT + 1);
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int AW    = $clog2(DEPTH);

    pool_state_e   state_q;
    logic [CW-1:0] width_q, col_q;
    logic [HW-1:0] height_q, row_q;
    fp16_t         h_q;
    fp16_t         out_data_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;

    fp16_t         rowbuf [DEPTH];

    fp16_t         px;
    fp16_t         hmax;
    fp16_t         vmax;
    fp16_t         rb_rd;
    logic [AW-1:0] rb_idx;
    logic          in_ready;
    logic          in_fire;
    logic          col_odd;
    logic          col_last;
    logic          row_last;

`ifdef MAXPOOL_RELU_CLAMP_EN
    assign px = fp16_relu_clamp(fp16_t'(strm.in_data));
`else
    assign px = fp16_t'(strm.in_data);
`endif

    assign in_ready = (state_q == ROW_EVEN) ||
                      (state_q == ROW_ODD && (!out_valid_q || strm.out_ready));
    assign in_fire  = strm.in_valid && in_ready;
    assign col_odd  = col_q[0];
    assign col_last = (col_q == width_q - 1'b1);
    assign row_last = (row_q == height_q - 1'b1);
    assign rb_idx   = AW'(col_q >> 1);
    assign rb_rd    = rowbuf[rb_idx];

    fp16_max u_max_h (
        .a_i (h_q),
        .b_i (px),
        .y_o (hmax)
    );

    fp16_max u_max_v (
        .a_i (rb_rd),
        .b_i (hmax),
        .y_o (vmax)
    );

    // Row buffer holds the horizontal maxima of the even row; no reset needed.
    always_ff @(posedge clk) begin
        if (in_fire && state_q == ROW_EVEN && col_odd) begin
            rowbuf[rb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= FP16_POS_ZERO;
            out_data_q  <= FP16_POS_ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_valid_q && strm.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        col_q    <= '0;
                        row_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ROW_EVEN;
                    end
                end

                ROW_EVEN, ROW_ODD: begin
                    if (in_fire) begin
                        // A trailing even column on odd widths lands in h_q and is never used.
                        if (!col_odd) begin
                            h_q <= px;
                        end else if (state_q == ROW_ODD) begin
                            out_data_q  <= vmax;
                            out_valid_q <= 1'b1;
                        end

                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            if (row_last) begin
                                state_q <= DRAIN;
                            end else begin
                                state_q <= (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (!out_valid_q || strm.out_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = DATA_WIDTH'(out_data_q);
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: directed scenarios plus randomized frames vs. a real-valued pooling model.
module tb_maxpool2x2_stream;

    typedef logic [15:0] pix_q_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] cfg_width = '0;
    logic [8:0] cfg_height = '0;
    logic       busy;
    logic       done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    maxpool2x2_stream_if #(.DATA_WIDTH(16)) bus ();

    maxpool2x2_stream #(
        .DATA_WIDTH (16),
        .MAX_WIDTH  (256),
        .MAX_HEIGHT (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .strm       (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic real fp16_val(logic [15:0] x);
        int  e;
        int  sh;
        real v;
        e = int'(x[14:10]);
        if (e == 0) begin
            v  = real'(int'(x[9:0]));
            sh = -24;
        end else begin
            v  = real'(1024 + int'(x[9:0]));
            sh = e - 25;
        end
        while (sh > 0) begin v = v * 2.0; sh--; end
        while (sh < 0) begin v = v * 0.5; sh++; end
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] model_in(logic [15:0] x);
`ifdef MAXPOOL_RELU_CLAMP_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [15:0] pick(logic [15:0] a, logic [15:0] b);
        return (fp16_val(a) >= fp16_val(b)) ? a : b;
    endfunction

    function automatic pix_q_t pool_ref(int w, int h, pix_q_t pix);
        pix_q_t r;
        logic [15:0] a, b, c, d;
        r = {};
        for (int y = 0; y < h / 2; y++) begin
            for (int x = 0; x < w / 2; x++) begin
                a = model_in(pix[(2*y)*w + 2*x]);
                b = model_in(pix[(2*y)*w + 2*x + 1]);
                c = model_in(pix[(2*y+1)*w + 2*x]);
                d = model_in(pix[(2*y+1)*w + 2*x + 1]);
                r.push_back(pick(pick(a, b), pick(c, d)));
            end
        end
        return r;
    endfunction

    // ---------------- frame driver ----------------
    // mode 0: out_ready always 1; mode 1: random out_ready;
    // mode 2: out_ready low for 5 cycles once the 6th pixel is accepted.
    task automatic run_frame(input int w, input int h, input pix_q_t pix,
                             input int mode, input bit rand_valid, input logic [15:0] hold_val,
                             output pix_q_t outs, output int done_cnt, output int acc,
                             output int last_hs, output int done_cyc, output logic busy_at_done,
                             output logic busy_after_start, output int hold_cycles,
                             output int hold_err);
        int idx, cyc, hold_left;
        bit hold_armed;
        outs = {};
        idx = 0; cyc = 0; hold_left = 0; hold_armed = 0;
        done_cnt = 0; last_hs = -1; done_cyc = -1; busy_at_done = 1'bx;
        busy_after_start = 1'bx; hold_cycles = 0; hold_err = 0;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cfg_width     = 9'(w);
        cfg_height    = 9'(h);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (done_cnt == 0 && cyc < 4000) begin
            bus.in_valid = (idx < pix.size()) && (!rand_valid || $urandom_range(0, 3) != 0);
            bus.in_data  = (idx < pix.size()) ? pix[idx] : 16'h0000;
            case (mode)
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                2:       bus.out_ready = (hold_left == 0);
                default: bus.out_ready = 1'b1;
            endcase

            @(negedge clk);
            if (cyc == 0) busy_after_start = busy;
            if (bus.in_valid && bus.in_ready) idx++;
            if (hold_left > 0) begin
                hold_cycles++;
                if (!(bus.out_valid === 1'b1 && bus.out_data === hold_val && bus.in_ready === 1'b0))
                    hold_err++;
                hold_left--;
            end else if (mode == 2 && !hold_armed && idx == 6) begin
                hold_left  = 5;
                hold_armed = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                outs.push_back(bus.out_data);
                last_hs = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            cyc++;
            @(posedge clk); #1;
        end
        acc = idx;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        pix_q_t pix, outs, exp;
        int dc, acc, lh, dcy, hc, he;
        logic bad, bas;
        pix = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00, 16'hBC00, 16'h3C00, 16'h4000, 16'h4400};
        exp = pool_ref(4, 2, pix);
        run_frame(4, 2, pix, 0, 0, 16'h0000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
        chk_cnt++; if (bas !== 1'b1) $display("FAIL basic_busy_after_start got=%b exp=1", bas); else pass_cnt++;
        chk_cnt++; if (outs.size() != 2) $display("FAIL basic_out_count got=%0d exp=2", outs.size()); else pass_cnt++;
        for (int i = 0; i < 2 && i < outs.size(); i++) begin
            chk_cnt++; if (outs[i] !== exp[i]) $display("FAIL basic_out%0d got=%h exp=%h", i, outs[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (dc != 1) $display("FAIL basic_done_count got=%0d exp=1", dc); else pass_cnt++;
        chk_cnt++; if (dcy != lh + 1) $display("FAIL basic_done_timing got=%0d exp=%0d", dcy, lh + 1); else pass_cnt++;
        chk_cnt++; if (bad !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", bad); else pass_cnt++;
        chk_cnt++; if (acc != 8) $display("FAIL basic_accepted got=%0d exp=8", acc); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        pix_q_t pix, outs, exp;
        int dc, acc, lh, dcy, hc, he;
        logic bad, bas;
        pix = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00, 16'hBC00, 16'h3C00, 16'h4000, 16'h4400};
        exp = pool_ref(4, 2, pix);
        run_frame(4, 2, pix, 2, 0, 16'h4000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
        chk_cnt++; if (hc != 5) $display("FAIL bp_hold_cycles got=%0d exp=5", hc); else pass_cnt++;
        chk_cnt++; if (he != 0) $display("FAIL bp_hold_stable got=%0d bad cycles exp=0", he); else pass_cnt++;
        chk_cnt++; if (outs.size() != 2) $display("FAIL bp_out_count got=%0d exp=2", outs.size()); else pass_cnt++;
        for (int i = 0; i < 2 && i < outs.size(); i++) begin
            chk_cnt++; if (outs[i] !== exp[i]) $display("FAIL bp_out%0d got=%h exp=%h", i, outs[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (acc != 8 || dc != 1) $display("FAIL bp_complete got acc=%0d done=%0d exp acc=8 done=1", acc, dc); else pass_cnt++;
    endtask

    task automatic test_odd_dims();
        pix_q_t pix, outs;
        int dc, acc, lh, dcy, hc, he;
        logic bad, bas;
        pix = {};
        for (int i = 0; i < 15; i++) pix.push_back(16'h3C00);
        run_frame(5, 3, pix, 0, 0, 16'h0000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
        chk_cnt++; if (outs.size() != 2) $display("FAIL odd_out_count got=%0d exp=2", outs.size()); else pass_cnt++;
        for (int i = 0; i < outs.size(); i++) begin
            chk_cnt++; if (outs[i] !== 16'h3C00) $display("FAIL odd_out%0d got=%h exp=3c00", i, outs[i]); else pass_cnt++;
        end
        chk_cnt++; if (acc != 15) $display("FAIL odd_accepted got=%0d exp=15", acc); else pass_cnt++;
        chk_cnt++; if (dc != 1) $display("FAIL odd_done got=%0d exp=1", dc); else pass_cnt++;
    endtask

    task automatic test_single_window(input string name, input pix_q_t pix, input logic [15:0] exp_val);
        pix_q_t outs;
        int dc, acc, lh, dcy, hc, he;
        logic bad, bas;
        run_frame(2, 2, pix, 0, 0, 16'h0000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
        chk_cnt++;
        if (outs.size() != 1 || outs[0] !== exp_val)
            $display("FAIL %s got=%h (n=%0d) exp=%h", name, (outs.size() > 0) ? outs[0] : 16'hxxxx, outs.size(), exp_val);
        else pass_cnt++;
    endtask

    task automatic test_signed_zero();
        pix_q_t pix;
        pix = '{16'h8000, 16'h0000, 16'h8000, 16'h8000};
`ifdef MAXPOOL_RELU_CLAMP_EN
        test_single_window("signed_zero", pix, 16'h0000);
`else
        test_single_window("signed_zero", pix, 16'h8000);
`endif
        pix = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400};
`ifdef MAXPOOL_RELU_CLAMP_EN
        test_single_window("neg_window", pix, 16'h0000);
`else
        test_single_window("neg_window", pix, 16'hBC00);
`endif
    endtask

    task automatic test_reset_midframe();
        pix_q_t pix, outs, exp;
        int dc, acc, lh, dcy, hc, he;
        logic bad, bas;
        bit done_seen;
        pix = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00, 16'hBC00, 16'h3C00, 16'h4000, 16'h4400};
        exp = pool_ref(4, 2, pix);
        cfg_width = 9'd4; cfg_height = 9'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = pix[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_outputs got ir=%b ov=%b od=%h busy=%b done=%b exp all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, busy, done);
        else pass_cnt++;
        done_seen = 0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) done_seen = 1; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (done === 1'b1) done_seen = 1; end
        chk_cnt++; if (done_seen) $display("FAIL midrst_no_done got=1 exp=0"); else pass_cnt++;
        @(posedge clk); #1;
        run_frame(4, 2, pix, 0, 0, 16'h0000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
        chk_cnt++; if (outs.size() != 2) $display("FAIL midrst_out_count got=%0d exp=2", outs.size()); else pass_cnt++;
        for (int i = 0; i < 2 && i < outs.size(); i++) begin
            chk_cnt++; if (outs[i] !== exp[i]) $display("FAIL midrst_out%0d got=%h exp=%h", i, outs[i], exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (dc != 1) $display("FAIL midrst_done got=%0d exp=1", dc); else pass_cnt++;
    endtask

    task automatic test_random();
        pix_q_t pix, outs, exp;
        int dc, acc, lh, dcy, hc, he, w, h;
        logic bad, bas;
        logic [15:0] p;
        for (int f = 0; f < 8; f++) begin
            w = (f == 0) ? 2 : int'($urandom_range(2, 11));
            h = (f == 0) ? 2 : int'($urandom_range(2, 7));
            pix = {};
            for (int i = 0; i < w * h; i++) begin
                if ($urandom_range(0, 7) == 0) p = {1'($urandom_range(0, 1)), 15'h0000};
                else p = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom)};
                pix.push_back(p);
            end
            exp = pool_ref(w, h, pix);
            run_frame(w, h, pix, 1, 1, 16'h0000, outs, dc, acc, lh, dcy, bad, bas, hc, he);
            chk_cnt++;
            if (outs.size() != exp.size()) $display("FAIL rand%0d_count got=%0d exp=%0d", f, outs.size(), exp.size());
            else pass_cnt++;
            for (int i = 0; i < outs.size() && i < exp.size(); i++) begin
                chk_cnt++;
                if (outs[i] !== exp[i]) $display("FAIL rand%0d_out%0d got=%h exp=%h", f, i, outs[i], exp[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (acc != w * h || dc != 1)
                $display("FAIL rand%0d_complete got acc=%0d done=%0d exp acc=%0d done=1", f, acc, dc, w * h);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_odd_dims();
        test_signed_zero();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
